// File: rtl/stream_reverser.sv
// -----------------------------------------------------------------------------
// stream_reverser
//
// Purpose:
//   Valid/ready stream stage that applies a per-word bit permutation to
//   WIDTH-bit words. The permutation is chosen by in_mode when a word is
//   accepted, and the permuted result is what gets stored:
//     0: pass through
//     1: full bit reversal
//     2: group-order reversal (GROUP-bit groups, bit order kept)
//     3: bit reversal inside each GROUP-bit group
//   Words are held in an output register plus one skid register, so in_ready
//   comes from a flop and never combinationally from out_ready.
//
// Ports:
//   clk         rising-edge clock
//   reset       synchronous, active-high reset
//   in_valid    producer has a word
//   in_ready    block can take a word (registered)
//   in_data     input word
//   in_mode     permutation select, sampled with in_data
//   out_valid   output word valid
//   out_ready   consumer takes the word
//   out_data    permuted word
//   xfer_count  number of completed output transfers, wraps
//   out_parity  XOR of all bits of out_data (only with the macro below)
//
// Configuration:
//   STREAM_REVERSER_PARITY_EN  when defined, adds out_parity and its storage.
// -----------------------------------------------------------------------------
module stream_reverser #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] xfer_count
`ifdef STREAM_REVERSER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  localparam int NGROUPS = WIDTH / GROUP;

  // Apply one of the four permutations to a word.
  function automatic logic [WIDTH-1:0] permute(input logic [WIDTH-1:0] data,
                                               input logic [1:0]       mode);
    logic [WIDTH-1:0] res;
    res = data;
    case (mode)
      2'd0: res = data;
      2'd1: begin
        for (int i = 0; i < WIDTH; i++) begin
          res[i] = data[WIDTH-1-i];
        end
      end
      2'd2: begin
        for (int k = 0; k < NGROUPS; k++) begin
          for (int j = 0; j < GROUP; j++) begin
            res[k*GROUP+j] = data[(NGROUPS-1-k)*GROUP+j];
          end
        end
      end
      2'd3: begin
        for (int k = 0; k < NGROUPS; k++) begin
          for (int j = 0; j < GROUP; j++) begin
            res[k*GROUP+j] = data[k*GROUP+GROUP-1-j];
          end
        end
      end
      default: res = data;
    endcase
    return res;
  endfunction

`ifdef STREAM_REVERSER_PARITY_EN
  // Even-parity bit of a word (XOR reduction).
  function automatic logic parity_of(input logic [WIDTH-1:0] data);
    return ^data;
  endfunction
`endif

  logic             oreg_valid_r;
  logic [WIDTH-1:0] oreg_data_r;
  logic             skid_valid_r;
  logic [WIDTH-1:0] skid_data_r;
  logic             in_ready_r;
  logic [CNT_W-1:0] cnt_r;

  logic             accept_s;
  logic             drain_s;
  logic             out_fire_s;
  logic [WIDTH-1:0] perm_s;
  logic             oreg_valid_n_s;
  logic             skid_valid_n_s;
  logic             load_oreg_skid_s;
  logic             load_oreg_in_s;
  logic             load_skid_in_s;

  assign accept_s   = in_valid & in_ready_r;
  // OREG can take a new word when it is empty or its word leaves this cycle.
  assign drain_s    = ~oreg_valid_r | out_ready;
  assign out_fire_s = oreg_valid_r & out_ready;
  assign perm_s     = permute(in_data, in_mode);

  // Decide where each word moves this cycle and the next occupancy.
  always_comb begin
    oreg_valid_n_s   = oreg_valid_r;
    skid_valid_n_s   = skid_valid_r;
    load_oreg_skid_s = 1'b0;
    load_oreg_in_s   = 1'b0;
    load_skid_in_s   = 1'b0;
    if (drain_s) begin
      if (skid_valid_r) begin
        // Oldest word is in SKID; it goes first to keep order.
        load_oreg_skid_s = 1'b1;
        load_skid_in_s   = accept_s;
        oreg_valid_n_s   = 1'b1;
        skid_valid_n_s   = accept_s;
      end else begin
        load_oreg_in_s   = accept_s;
        oreg_valid_n_s   = accept_s;
        skid_valid_n_s   = 1'b0;
      end
    end else begin
      // OREG stalled: an accepted word parks in SKID.
      load_skid_in_s = accept_s;
      oreg_valid_n_s = oreg_valid_r;
      skid_valid_n_s = skid_valid_r | accept_s;
    end
  end

  // Occupancy, ready flag and transfer counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      oreg_valid_r <= 1'b0;
      skid_valid_r <= 1'b0;
      in_ready_r   <= 1'b0;
      cnt_r        <= {CNT_W{1'b0}};
    end else begin
      oreg_valid_r <= oreg_valid_n_s;
      skid_valid_r <= skid_valid_n_s;
      in_ready_r   <= ~skid_valid_n_s;
      if (out_fire_s) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end else begin
        cnt_r <= cnt_r;
      end
    end
  end

  // Word storage for OREG and SKID.
  always_ff @(posedge clk) begin
    if (reset) begin
      oreg_data_r <= {WIDTH{1'b0}};
      skid_data_r <= {WIDTH{1'b0}};
    end else begin
      if (load_oreg_skid_s) begin
        oreg_data_r <= skid_data_r;
      end else if (load_oreg_in_s) begin
        oreg_data_r <= perm_s;
      end else begin
        oreg_data_r <= oreg_data_r;
      end
      if (load_skid_in_s) begin
        skid_data_r <= perm_s;
      end else begin
        skid_data_r <= skid_data_r;
      end
    end
  end

`ifdef STREAM_REVERSER_PARITY_EN
  logic oreg_par_r;
  logic skid_par_r;

  // Parity travels alongside its word through OREG and SKID.
  always_ff @(posedge clk) begin
    if (reset) begin
      oreg_par_r <= 1'b0;
      skid_par_r <= 1'b0;
    end else begin
      if (load_oreg_skid_s) begin
        oreg_par_r <= skid_par_r;
      end else if (load_oreg_in_s) begin
        oreg_par_r <= parity_of(perm_s);
      end else begin
        oreg_par_r <= oreg_par_r;
      end
      if (load_skid_in_s) begin
        skid_par_r <= parity_of(perm_s);
      end else begin
        skid_par_r <= skid_par_r;
      end
    end
  end

  assign out_parity = oreg_par_r;
`endif

  assign in_ready   = in_ready_r;
  assign out_valid  = oreg_valid_r;
  assign out_data   = oreg_data_r;
  assign xfer_count = cnt_r;

endmodule

// File: tb/tb_stream_reverser.sv
// -----------------------------------------------------------------------------
// tb_stream_reverser
//
// Self-checking bench for stream_reverser. Main instance uses WIDTH=32,
// GROUP=8, CNT_W=16; a second instance with CNT_W=4 checks counter wrap.
// Inputs are driven 1 time unit after the rising edge; outputs are sampled
// either right after the edge or on the falling edge.
// -----------------------------------------------------------------------------
module tb_stream_reverser;

  localparam int W  = 32;
  localparam int G  = 8;
  localparam int NW = 1000;

  logic          clk;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_data;
  logic [15:0]   xfer_count;
`ifdef STREAM_REVERSER_PARITY_EN
  logic          out_parity;
  logic          c_out_parity;
`endif

  logic          c_in_valid;
  logic          c_in_ready;
  logic [W-1:0]  c_in_data;
  logic [1:0]    c_in_mode;
  logic          c_out_valid;
  logic          c_out_ready;
  logic [W-1:0]  c_out_data;
  logic [3:0]    c_xfer_count;

  int checks;
  int failures;

  stream_reverser #(.WIDTH(W), .GROUP(G), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .xfer_count (xfer_count)
`ifdef STREAM_REVERSER_PARITY_EN
    ,
    .out_parity (out_parity)
`endif
  );

  stream_reverser #(.WIDTH(W), .GROUP(G), .CNT_W(4)) dut_cnt (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (c_in_valid),
    .in_ready   (c_in_ready),
    .in_data    (c_in_data),
    .in_mode    (c_in_mode),
    .out_valid  (c_out_valid),
    .out_ready  (c_out_ready),
    .out_data   (c_out_data),
    .xfer_count (c_xfer_count)
`ifdef STREAM_REVERSER_PARITY_EN
    ,
    .out_parity (c_out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference permutation built from shifts and masks on whole groups.
  function automatic logic [31:0] ref_perm(input logic [31:0] d, input int mode);
    logic [31:0] r;
    logic [31:0] gmask;
    logic [31:0] g;
    logic [31:0] rg;
    int ng;
    ng    = W / G;
    gmask = (32'h1 << G) - 32'h1;
    r     = 32'h0;
    case (mode)
      0: r = d;
      1: for (int i = 0; i < W; i++) r = r | (((d >> i) & 32'h1) << (W - 1 - i));
      2: for (int k = 0; k < ng; k++) r = r | (((d >> (k * G)) & gmask) << ((ng - 1 - k) * G));
      3: begin
        for (int k = 0; k < ng; k++) begin
          g  = (d >> (k * G)) & gmask;
          rg = 32'h0;
          for (int j = 0; j < G; j++) rg = rg | (((g >> j) & 32'h1) << (G - 1 - j));
          r = r | (rg << (k * G));
        end
      end
      default: r = d;
    endcase
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) step();
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL reset_count: got %0d expected 0", xfer_count); end
    reset = 1'b0;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_out_valid: got %b expected 0", out_valid); end
    checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL release_count: got %0d expected 0", xfer_count); end
  endtask

  task automatic test_counter_wrap();
    c_in_valid = 1'b1;
    for (int n = 0; n < 17; n++) begin
      c_in_data = $urandom;
      c_in_mode = 2'($urandom_range(0, 3));
      checks++; if (c_in_ready !== 1'b1) begin failures++; $display("FAIL wrap_in_ready: word %0d got %b expected 1", n, c_in_ready); end
      step();
    end
    c_in_valid = 1'b0;
    repeat (2) step();
    checks++; if (c_xfer_count !== 4'd1) begin failures++; $display("FAIL wrap_count: got %0d expected 1", c_xfer_count); end
    checks++; if (c_out_valid !== 1'b0) begin failures++; $display("FAIL wrap_out_valid: got %b expected 0", c_out_valid); end
  endtask

  task automatic test_modes();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'h12345678;
    exp_tab[1] = 32'h1E6A2C48;
    exp_tab[2] = 32'h78563412;
    exp_tab[3] = 32'h482C6A1E;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h12345678;
    for (int m = 0; m < 4; m++) begin
      in_mode = 2'(m);
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_tab[m]) begin
        failures++;
        $display("FAIL mode%0d: got valid=%b data=%h expected valid=1 data=%h", m, out_valid, out_data, exp_tab[m]);
      end
    end
    in_valid = 1'b0;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL modes_drain: got valid=%b expected 0", out_valid); end
    checks++; if (xfer_count !== 16'd4) begin failures++; $display("FAIL modes_count: got %0d expected 4", xfer_count); end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd0;
    in_data   = 32'h1;
    step();
    in_data   = 32'h2;
    step();
    in_valid  = 1'b0;
    for (int n = 0; n < 3; n++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready: got %b expected 0", in_ready); end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h1) begin
        failures++;
        $display("FAIL bp_hold: got valid=%b data=%h expected valid=1 data=1", out_valid, out_data);
      end
      step();
    end
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h2) begin
      failures++;
      $display("FAIL bp_second: got valid=%b data=%h expected valid=1 data=2", out_valid, out_data);
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back: got %b expected 1", in_ready); end
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_empty: got %b expected 0", out_valid); end
    checks++; if (xfer_count !== 16'd6) begin failures++; $display("FAIL bp_count: got %0d expected 6", xfer_count); end
  endtask

  task automatic test_midstream_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'd1;
    in_data   = $urandom;
    step();
    in_data   = $urandom;
    step();
    in_valid  = 1'b0;
    reset     = 1'b1;
    step();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_valid: got %b expected 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL mid_reset_ready: got %b expected 0", in_ready); end
    checks++; if (xfer_count !== 16'd0) begin failures++; $display("FAIL mid_reset_count: got %0d expected 0", xfer_count); end
    reset     = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL mid_release_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_ghost_word: got %b expected 0", out_valid); end
  endtask

  task automatic test_random();
    logic [31:0] q [$];
    logic        pq [$];
    logic [31:0] exp_w;
    logic        exp_p;
    logic        inf;
    logic        outf;
    logic        held;
    logic [31:0] held_data;
    int          sent;
    int          recv;
    int          cyc;
    sent = 0; recv = 0; cyc = 0;
    inf = 1'b0; held = 1'b0; held_data = 32'h0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    while ((sent < NW || q.size() > 0) && cyc < 30000) begin
      @(negedge clk);
      cyc++;
      inf  = in_valid && in_ready;
      outf = out_valid && out_ready;
      if (held) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== held_data) begin
          failures++;
          $display("FAIL rand_stable: got valid=%b data=%h expected valid=1 data=%h", out_valid, out_data, held_data);
        end
      end
      if (outf) begin
        checks++;
        recv++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL rand_extra_word: got %h expected no word", out_data);
        end else begin
          exp_w = q.pop_front();
          exp_p = pq.pop_front();
          if (out_data !== exp_w) begin
            failures++;
            $display("FAIL rand_data: word %0d got %h expected %h", recv, out_data, exp_w);
          end
`ifdef STREAM_REVERSER_PARITY_EN
          checks++;
          if (out_parity !== exp_p) begin
            failures++;
            $display("FAIL rand_parity: word %0d got %b expected %b", recv, out_parity, exp_p);
          end
`endif
        end
      end
      if (inf) begin
        q.push_back(ref_perm(in_data, int'(in_mode)));
        pq.push_back(^in_data);
        sent++;
      end
      held = out_valid && !out_ready;
      held_data = out_data;
      @(posedge clk);
      #1;
      if (!in_valid || inf) begin
        in_valid = (sent < NW) && ($urandom_range(0, 3) != 0);
        in_data  = $urandom;
        in_mode  = 2'($urandom_range(0, 3));
      end
      out_ready = ($urandom_range(0, 2) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (sent != NW || recv != NW || q.size() != 0) begin
      failures++;
      $display("FAIL rand_complete: got sent=%0d recv=%0d pending=%0d expected %0d/%0d/0", sent, recv, q.size(), NW, NW);
    end
    checks++; if (xfer_count !== 16'd1000) begin failures++; $display("FAIL rand_count: got %0d expected 1000", xfer_count); end
  endtask

`ifdef STREAM_REVERSER_PARITY_EN
  task automatic test_parity();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_mode   = 2'($urandom_range(0, 3));
    in_data   = 32'h12345678;
    step();
    in_valid  = 1'b0;
    checks++; if (out_parity !== 1'b1) begin failures++; $display("FAIL parity_odd: got %b expected 1", out_parity); end
    step();
    checks++; if (out_parity !== 1'b1) begin failures++; $display("FAIL parity_hold: got %b expected 1", out_parity); end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'h3;
    step();
    in_valid  = 1'b0;
    checks++; if (out_parity !== 1'b0) begin failures++; $display("FAIL parity_even: got %b expected 0", out_parity); end
    out_ready = 1'b1;
    step();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = 32'h0;
    in_mode = 2'd0;
    out_ready = 1'b0;
    c_in_valid = 1'b0;
    c_in_data = 32'h0;
    c_in_mode = 2'd0;
    c_out_ready = 1'b1;
    test_reset();
    test_counter_wrap();
    test_modes();
    test_backpressure();
    test_midstream_reset();
    test_random();
`ifdef STREAM_REVERSER_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stream_reverser.md
Name: stream_reverser

Overview:
Parametrised, handshaked successor to the combinational 8-bit reverser. It accepts WIDTH-bit words on a valid/ready stream and applies a per-word selectable permutation: pass, full bit reversal, group-order reversal, or bit reversal within each group. The result is registered with a 2-entry skid buffer so that out_ready is never combinationally tied to in_ready. It sits between a producer and a consumer in datapath stages that need endianness or bit-order conversion.

Parameters:
WIDTH, 32, data width in bits; must be ≥ 2 and a multiple of GROUP.
GROUP, 8, group size in bits for modes 2 and 3; must be ≥ 1 and divide WIDTH.
CNT_W, 16, width of the transfer counter.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  synchronous, active-high reset.
in_valid  input  1  input word valid.
in_ready  output  1  block can accept a word.
in_data  input  WIDTH  input word.
in_mode  input  2  permutation for this word; sampled with in_data.
out_valid  output  1  output word valid.
out_ready  input  1  consumer accepts the word.
out_data  output  WIDTH  permuted word.
xfer_count  output  CNT_W  count of completed output transfers.

Behaviour:
- Reset is synchronous and active-high, sampled on the clk rising edge. Reset values: in_ready=0 while reset is high, then 1 on the first cycle after reset. out_valid=0, out_data=0, xfer_count=0, skid entry empty.
- Handshake rules:
  - An input transfer occurs when in_valid & in_ready.
  - An output transfer occurs when out_valid & out_ready.
  - out_data and out_valid stay stable while out_valid=1 & out_ready=0.
- The mode is applied at acceptance. The permuted word is stored, so a change to in_mode never alters a word already accepted.
- Modes, where bit i is an output bit index and G=GROUP:
  - 0: pass; out[i]=in[i].
  - 1: full bit reversal; out[i]=in[WIDTH-1-i].
  - 2: group-order reversal; group k of the output = group (WIDTH/G-1-k) of the input, with bit order inside each group kept.
  - 3: bit reversal within each group; out[k*G+j]=in[k*G+G-1-j].
  - With GROUP=1, mode 2 equals mode 1 and mode 3 equals mode 0.
- Storage: an output register (OREG) and one skid register (SKID).
- in_ready = !SKID_valid, driven from a register only.
- Latency: 1 cycle from an input transfer to out_valid when OREG is empty or draining. Throughput: 1 word per cycle when out_ready is held high.
- Per-cycle update, evaluated after reset:
  - If OREG is empty or draining (!out_valid | out_ready):
    - If SKID holds a word, SKID moves to OREG, and any word accepted this cycle enters SKID.
    - Otherwise, a word accepted this cycle enters OREG directly; with no accepted word, OREG becomes empty.
  - If OREG is stalled and a word is accepted, it enters SKID and in_ready drops next cycle.
- Order: words leave in exactly the order they were accepted. No drop and no duplication.
- A simultaneous input and output transfer with SKID full cannot occur, because in_ready=0 when SKID is full.
- xfer_count increments by 1 on each output transfer and wraps modulo 2^CNT_W with no saturation.
- Reset mid-stream discards both entries next cycle; the counter returns to 0.

Optional Feature:
Macro STREAM_REVERSER_PARITY_EN.
- Defined: adds output port out_parity (1 bit). It equals the XOR of all bits of the stored out_data, is registered with the word, has reset value 0, and stays stable under backpressure. The permutation does not change parity, so it also equals the XOR of the accepted in_data.
- Undefined: the port and its logic are absent. All other behaviour is identical.

Test Plan (WIDTH=32, GROUP=8 unless stated):
- Reset held for 2 cycles, then released -> out_valid=0, xfer_count=0, in_ready=1 on the cycle after release.
- in_data=0x12345678 sent with modes 0, 1, 2, 3 back-to-back, out_ready=1 -> out_data is 0x12345678, 0x1E6A2C48, 0x78563412, 0x482C6A1E on consecutive cycles starting one cycle after the first transfer; xfer_count=4.
- Backpressure: out_ready=0, send words A=0x1, B=0x2 in mode 0 -> after B, in_ready=0, out_data=0x1 held stable. Raise out_ready -> A then B are delivered in order and in_ready returns to 1.
- Random valid/ready toggling over 1000 words with random modes, checked against a reference model -> exact sequence match, no drops, xfer_count=1000.
- CNT_W=4, 17 transfers -> xfer_count=1.
- With STREAM_REVERSER_PARITY_EN defined, in_data=0x12345678 -> out_parity=1; in_data=0x3 -> out_parity=0.
